// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice plus a carry flop, LSB first.
// Sum and carry-out are registered on completion and held until the next result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_s, fa_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    fa_s    = a_q[0] ^ b_q[0] ^ c_q;
    fa_c    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = cin_i;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        c_d          = fa_c;
        // Shift the new sum bit in at the top; also covers WIDTH=1.
        s_d          = s_q >> 1;
        s_d[WIDTH-1] = fa_s;
        cnt_d        = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = s_d;
          cout_d  = fa_c;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q == StShift);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1: vector table,
// handshake/back-to-back/reset corner sequences, and random checks vs. a+b+cin.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .start_i(start8),
    .a_i    (a8),
    .b_i    (b8),
    .cin_i  (cin8),
    .busy_o (busy8),
    .done_o (done8),
    .sum_o  (sum8),
    .cout_o (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start_i(start1),
    .a_i    (a1),
    .b_i    (b1),
    .cin_i  (cin1),
    .busy_o (busy1),
    .done_o (done1),
    .sum_o  (sum1),
    .cout_o (cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full WIDTH=8 addition with cycle-exact busy/done checks; inputs change
  // after the start edge to show they are not resampled.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_sum, input logic exp_cout);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("busy8 during shift", 64'(busy8), 64'd1);
      check("done8 during shift", 64'(done8), 64'd0);
      @(negedge clk);
    end
    check("done8 pulse", 64'(done8), 64'd1);
    check("busy8 in done", 64'(busy8), 64'd0);
    check("sum8", 64'(sum8), 64'(exp_sum));
    check("cout8", 64'(cout8), 64'(exp_cout));
    @(negedge clk);
    check("done8 one cycle", 64'(done8), 64'd0);
    check("sum8 held", 64'(sum8), 64'(exp_sum));
  endtask

  task automatic add1(input logic a, input logic b, input logic c);
    logic [1:0] ref_v;
    ref_v = 2'(a) + 2'(b) + 2'(c);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    @(negedge clk);
    start1 = 1'b0;
    check("busy1", 64'(busy1), 64'd1);
    check("done1 early", 64'(done1), 64'd0);
    @(negedge clk);
    check("done1 pulse", 64'(done1), 64'd1);
    check("res1", 64'({cout1, sum1}), 64'(ref_v));
  endtask

  initial begin
    logic [8:0] ref_v;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb;
    int         dones;

    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy8", 64'(busy8), 64'd0);
    check("rst done8", 64'(done8), 64'd0);
    check("rst sum8", 64'(sum8), 64'd0);
    check("rst cout8", 64'(cout8), 64'd0);
    check("rst res1", 64'({busy1, done1, cout1, sum1}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      add8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout);
    end

    // start held high with changing operands: only operands present in idle/done are taken.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    qa.push_back(8'h12); qb.push_back(8'h34);
    dones = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("held-start done timing", 64'(done8), 64'((c == 8) || (c == 17)));
      if (done8) begin
        dones++;
        ea = qa.pop_front(); eb = qb.pop_front();
        ref_v = 9'(ea) + 9'(eb);
        check("held-start result", 64'({cout8, sum8}), 64'(ref_v));
      end
      if (c == 17) begin
        start8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        if (c == 8) begin
          qa.push_back(a8); qb.push_back(b8);
        end
      end
    end
    check("held-start done count", 64'(dones), 64'd2);
    @(negedge clk);
    check("held-start idle", 64'({busy8, done8}), 64'd0);

    // Back-to-back: new start in the done cycle; old sum held through the next addition.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b first done", 64'(done8), 64'd1);
    check("b2b first sum", 64'(sum8), 64'h7F);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("b2b busy", 64'(busy8), 64'd1);
      check("b2b sum held", 64'(sum8), 64'h7F);
      @(negedge clk);
    end
    check("b2b second done", 64'(done8), 64'd1);
    check("b2b second sum", 64'({cout8, sum8}), 64'h003);

    // Reset mid-addition (cnt==4) aborts with no done pulse.
    add8(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort sum", 64'(sum8), 64'd0);
    check("abort cout", 64'(cout8), 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ea = 8'($urandom); eb = 8'($urandom);
      cin8 = 1'($urandom);
      ref_v = 9'(ea) + 9'(eb) + 9'(cin8);
      add8(ea, eb, cin8, ref_v[7:0], ref_v[8]);
    end
    for (int i = 0; i < 1000; i++) begin
      add1(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
